// File: rtl/interconnect_pkg.sv
// Shared definitions for the interconnect output side: default widths,
// the per-slave receive status record and the rx flow-control states.
package interconnect_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DROP_CNT_W_DEF = 8;
  localparam int RX_DEPTH_DEF   = 8;
  localparam int RX_LEVEL_W_DEF = $clog2(RX_DEPTH_DEF) + 1;

  typedef struct packed {
    logic                      overflow;
    logic [DROP_CNT_W_DEF-1:0] drop_count;
    logic [RX_LEVEL_W_DEF-1:0] level;
  } rx_status_t;

  // Flow-control view of the receive buffer, derived from occupancy.
  typedef enum logic {
    FC_ACCEPT = 1'b0,
    FC_FULL   = 1'b1
  } fc_state_t;

endpackage

// File: rtl/slave_rx_buffer_if.sv
// Delivery, consumer handshake and status signals of one per-slave rx buffer.
// The slave modport is the buffer side; master is the interconnect/consumer side.
interface slave_rx_buffer_if
  import interconnect_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = RX_DEPTH_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] slave_data;
  logic                  slave_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [LVL_W-1:0]      level;
  logic                  almost_full;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_count;
  logic                  clr_overflow;

  modport slave (
    input  slave_data, slave_valid, rd_ready, clr_overflow,
    output rd_data, rd_valid, level, almost_full, overflow, drop_count
  );

  modport master (
    output slave_data, slave_valid, rd_ready, clr_overflow,
    input  rd_data, rd_valid, level, almost_full, overflow, drop_count
  );

endinterface

// File: rtl/rx_fifo_mem.sv
// Storage array for the rx buffer: one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module rx_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/slave_rx_buffer.sv
// Per-slave receive FIFO behind the interconnect. Deliveries cannot be
// back-pressured, so arrivals at full are dropped, flagged and counted.
module slave_rx_buffer
  import interconnect_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = RX_DEPTH_DEF,
  parameter int AFULL_LEVEL = 6,
  parameter int DROP_CNT_W  = DROP_CNT_W_DEF
) (
  input  logic             pclk,
  input  logic             rstn,
  slave_rx_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      LVL_AFULL = LVL_W'(AFULL_LEVEL);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_rd_valid;
  logic                  r_almost_full;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  fc_state_t             w_fc_state;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [LVL_W-1:0]      w_level_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Flow-control state is a pure function of occupancy, never stored.
  assign w_fc_state = (r_level == LVL_FULL) ? FC_FULL : FC_ACCEPT;
  assign w_pop      = r_rd_valid & bus.rd_ready;

  // Decide whether this cycle's delivery is stored or dropped.
  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    case (w_fc_state)
      FC_ACCEPT: begin
        w_push = bus.slave_valid;
        w_drop = 1'b0;
      end
      FC_FULL: begin
        if (bus.slave_valid && w_pop) begin
          w_push = 1'b1;
          w_drop = 1'b0;
        end else if (bus.slave_valid) begin
          w_push = 1'b0;
          w_drop = 1'b1;
        end else begin
          w_push = 1'b0;
          w_drop = 1'b0;
        end
      end
      default: begin
        w_push = 1'b0;
        w_drop = 1'b0;
      end
    endcase
  end

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers, occupancy and the status flags derived from it.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr      <= {PTR_W{1'b0}};
      r_rd_ptr      <= {PTR_W{1'b0}};
      r_level       <= {LVL_W{1'b0}};
      r_rd_valid    <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level       <= w_level_nxt;
      r_rd_valid    <= (w_level_nxt != {LVL_W{1'b0}});
      r_almost_full <= (w_level_nxt >= LVL_AFULL);
    end
  end

  // Drop bookkeeping; a drop in the clearing cycle counts as the first new drop.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {DROP_CNT_W{1'b0}};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.clr_overflow) begin
        r_drop_count <= DROP_CNT_W'(1);
      end else if (r_drop_count != DROP_MAX) begin
        r_drop_count <= r_drop_count + DROP_CNT_W'(1);
      end
    end else if (bus.clr_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {DROP_CNT_W{1'b0}};
    end
  end

  rx_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .i_clk   (pclk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.slave_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.level       = r_level;
  assign bus.almost_full = r_almost_full;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_count;

endmodule

// File: tb/tb_slave_rx_buffer.sv
// Directed bench for slave_rx_buffer (DEPTH=8, AFULL_LEVEL=6, 8-bit drop counter).
module tb_slave_rx_buffer;

  logic pclk;
  logic rstn;
  int   total;
  int   bad;

  slave_rx_buffer_if #(.DATA_WIDTH(32), .DEPTH(8), .DROP_CNT_W(8)) bus ();

  slave_rx_buffer #(
    .DATA_WIDTH  (32),
    .DEPTH       (8),
    .AFULL_LEVEL (6),
    .DROP_CNT_W  (8)
  ) u_dut (
    .pclk (pclk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
    bus.slave_valid = v;
    bus.slave_data  = d;
    bus.rd_ready    = rdy;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.clr_overflow = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);

    // Reset held with deliveries present
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("rst_level", 32'(bus.level), 32'd0);
      check_val("rst_valid", 32'(bus.rd_valid), 32'd0);
      check_val("rst_ovf", 32'(bus.overflow), 32'd0);
    end
    check_val("rst_afull", 32'(bus.almost_full), 32'd0);
    check_val("rst_drops", 32'(bus.drop_count), 32'd0);

    rstn = 1'b1;
    drive(1'b1, 32'hA5A5_0001, 1'b0);
    tick();
    check_val("first_valid", 32'(bus.rd_valid), 32'd1);
    check_val("first_data", bus.rd_data, 32'hA5A5_0001);
    check_val("first_level", 32'(bus.level), 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check_val("first_pop_level", 32'(bus.level), 32'd0);
    check_val("first_pop_valid", 32'(bus.rd_valid), 32'd0);

    // Fill past full: 10 pushes, 2 drops
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      tick();
      check_val("fill_level", 32'(bus.level), (i < 8) ? 32'(i + 1) : 32'd8);
      check_val("fill_afull", 32'(bus.almost_full), (i >= 5) ? 32'd1 : 32'd0);
      check_val("fill_drops", 32'(bus.drop_count), (i >= 8) ? 32'(i - 7) : 32'd0);
      check_val("fill_ovf", 32'(bus.overflow), (i >= 8) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 32'h0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      check_val("drain_data", bus.rd_data, 32'(j));
      check_val("drain_valid", 32'(bus.rd_valid), 32'd1);
      tick();
    end
    check_val("drain_level", 32'(bus.level), 32'd0);
    check_val("drain_valid_end", 32'(bus.rd_valid), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 1'b0);
      tick();
    end
    check_val("full_level", 32'(bus.level), 32'd8);
    drive(1'b1, 32'h100, 1'b1);
    check_val("full_head", bus.rd_data, 32'h10);
    tick();
    check_val("pp_level", 32'(bus.level), 32'd8);
    check_val("pp_drops", 32'(bus.drop_count), 32'd2);
    drive(1'b0, 32'h0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      check_val("pp_drain", bus.rd_data, (j < 7) ? (32'h11 + 32'(j)) : 32'h100);
      tick();
    end
    check_val("pp_empty", 32'(bus.level), 32'd0);

    // Streaming through the pointer wrap
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 1'b1);
      tick();
      check_val("strm_valid", 32'(bus.rd_valid), 32'd1);
      check_val("strm_data", bus.rd_data, 32'h200 + 32'(i));
      check_val("strm_level", 32'(bus.level), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check_val("strm_empty", 32'(bus.level), 32'd0);
    check_val("strm_drops", 32'(bus.drop_count), 32'd2);

    // Saturate the drop counter: 8 stored then 253 drops
    for (int i = 0; i < 261; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 1'b0);
      tick();
    end
    check_val("sat_255", 32'(bus.drop_count), 32'd255);
    tick();
    check_val("sat_hold", 32'(bus.drop_count), 32'd255);
    check_val("sat_ovf", 32'(bus.overflow), 32'd1);
    bus.clr_overflow = 1'b1;
    tick();
    check_val("clrdrop_ovf", 32'(bus.overflow), 32'd1);
    check_val("clrdrop_cnt", 32'(bus.drop_count), 32'd1);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check_val("clr_ovf", 32'(bus.overflow), 32'd0);
    check_val("clr_cnt", 32'(bus.drop_count), 32'd0);
    bus.clr_overflow = 1'b0;
    check_val("clr_head", bus.rd_data, 32'h300);

    // Asynchronous reset with 5 words queued
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 32'h0, 1'b0);
    check_val("mid_level", 32'(bus.level), 32'd5);
    #2;
    rstn = 1'b0;
    #1;
    check_val("async_level", 32'(bus.level), 32'd0);
    check_val("async_valid", 32'(bus.rd_valid), 32'd0);
    #1;
    rstn = 1'b1;
    drive(1'b1, 32'h55, 1'b0);
    tick();
    check_val("post_rst_valid", 32'(bus.rd_valid), 32'd1);
    check_val("post_rst_data", bus.rd_data, 32'h55);
    check_val("post_rst_level", 32'(bus.level), 32'd1);
    drive(1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
